// File: rtl/captune_seq.sv
// Sequencer for thermometer-coded tunable cap banks: binary targets in, registered
// thermometer words out, with immediate jumps or one-unit-per-STEP_DIV ramps.
module captune_seq #(
    parameter int N_UNITS    = 64,
    parameter int N_CH       = 2,
    parameter int STEP_DIV   = 4,
    parameter int RESET_CODE = 32,
    localparam int CW  = $clog2(N_UNITS + 1),
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CHW-1:0]          cfg_ch,
    input  logic [CW-1:0]           cfg_code,
    input  logic                    cfg_ramp,
    input  logic                    hold,
    output logic [N_CH*N_UNITS-1:0] tune,
    output logic [N_CH*CW-1:0]      cur_code,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done
);
    localparam int DW = $clog2(STEP_DIV) + 1;
    localparam logic [DW-1:0] DIV_RELOAD = DW'(STEP_DIV - 1);

    typedef enum logic {IDLE, RAMP} st_e;

    function automatic logic [N_UNITS-1:0] therm(input logic [CW-1:0] n);
        logic [N_UNITS-1:0] t;
        for (int i = 0; i < N_UNITS; i++) t[i] = (CW'(i) < n);
        return t;
    endfunction

    logic          cfg_ready_q;
    logic [CW-1:0] code_clamped;

    always_ff @(posedge clk) begin
        if (!rst_n) cfg_ready_q <= 1'b0;
        else        cfg_ready_q <= 1'b1;
    end

    assign cfg_ready    = cfg_ready_q;
    assign code_clamped = (cfg_code > CW'(N_UNITS)) ? CW'(N_UNITS) : cfg_code;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        st_e                state_q, state_d;
        logic [CW-1:0]      cur_q, cur_d, tgt_q, tgt_d, step_code;
        logic [DW-1:0]      div_q, div_d;
        logic               done_q, done_d, busy_c;
        logic [N_UNITS-1:0] tune_q;
        logic               wr;

        // Channels beyond N_CH never match, so such writes are accepted and dropped.
        assign wr = cfg_valid && cfg_ready_q && (cfg_ch == CHW'(c));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cur_q   <= CW'(RESET_CODE);
                tgt_q   <= CW'(RESET_CODE);
                div_q   <= '0;
                done_q  <= 1'b0;
                tune_q  <= therm(CW'(RESET_CODE));
            end else begin
                state_q <= state_d;
                cur_q   <= cur_d;
                tgt_q   <= tgt_d;
                div_q   <= div_d;
                done_q  <= done_d;
                tune_q  <= therm(cur_d);
            end
        end

        always_comb begin
            state_d   = state_q;
            cur_d     = cur_q;
            tgt_d     = tgt_q;
            div_d     = div_q;
            done_d    = 1'b0;
            step_code = (cur_q < tgt_q) ? cur_q + CW'(1) : cur_q - CW'(1);
            if (wr) begin
                // A write always wins over a pending step; the old target is dropped silently.
                tgt_d = code_clamped;
                if (!cfg_ramp) begin
                    cur_d   = code_clamped;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (code_clamped == cur_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RAMP;
                    div_d   = DIV_RELOAD;
                end
            end else if (state_q == RAMP && !hold) begin
                if (div_q != '0) begin
                    div_d = div_q - DW'(1);
                end else begin
                    cur_d = step_code;
                    div_d = DIV_RELOAD;
                    if (step_code == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end

        always_comb begin
            busy_c = (state_q == RAMP);
        end

        assign tune[c*N_UNITS +: N_UNITS] = tune_q;
        assign cur_code[c*CW +: CW]       = cur_q;
        assign busy[c]                    = busy_c;
        assign done[c]                    = done_q;
    end

endmodule

// File: tb/tb_captune_seq.sv
// Directed bench for captune_seq: vector table for single-cycle behaviour plus
// hand-written ramp, redirect/hold and reset-mid-ramp sequences.
module tb_captune_seq;
    localparam int NU = 64;
    localparam int NC = 2;
    localparam int CW = 7;

    logic              clk = 1'b0;
    logic              rst_n, cfg_valid, cfg_ready, cfg_ch, cfg_ramp, hold;
    logic [CW-1:0]     cfg_code;
    logic [NC*NU-1:0]  tune;
    logic [NC*CW-1:0]  cur_code;
    logic [NC-1:0]     busy, done;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    captune_seq #(.N_UNITS(NU), .N_CH(NC), .STEP_DIV(4), .RESET_CODE(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_code(cfg_code), .cfg_ramp(cfg_ramp), .hold(hold),
        .tune(tune), .cur_code(cur_code), .busy(busy), .done(done)
    );

    typedef struct {
        logic r, v, ch;
        int   code;
        logic rp, h;
        int   c0, c1;
        logic [1:0] b, d;
        logic rdy;
    } vec_t;

    function automatic logic [63:0] therm(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic vec_t mk(input logic r, v, ch, input int code, input logic rp, h,
                                input int c0, c1, input logic [1:0] b, d, input logic rdy);
        vec_t t;
        t.r = r; t.v = v; t.ch = ch; t.code = code; t.rp = rp; t.h = h;
        t.c0 = c0; t.c1 = c1; t.b = b; t.d = d; t.rdy = rdy;
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic apply(input logic r, v, ch, input int code, input logic rp, h);
        @(negedge clk);
        rst_n = r; cfg_valid = v; cfg_ch = ch; cfg_code = CW'(code); cfg_ramp = rp; hold = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int c0, c1, input logic [1:0] eb, ed,
                         input logic er);
        cmp({nm, " cur0"}, 64'(cur_code[CW-1:0]), 64'(c0));
        cmp({nm, " cur1"}, 64'(cur_code[2*CW-1:CW]), 64'(c1));
        cmp({nm, " tune0"}, tune[NU-1:0], therm(c0));
        cmp({nm, " tune1"}, tune[2*NU-1:NU], therm(c1));
        cmp({nm, " busy"}, 64'(busy), 64'(eb));
        cmp({nm, " done"}, 64'(done), 64'(ed));
        cmp({nm, " ready"}, 64'(cfg_ready), 64'(er));
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_code = '0; cfg_ramp = 1'b0; hold = 1'b0;

        //            r  v  ch code rp h   c0  c1  busy   done   rdy
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 32, 32, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 32, 32, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 32, 32, 2'b00, 2'b00, 1));
        tbl.push_back(mk(1, 1, 0, 50,  0, 0, 50, 32, 2'b00, 2'b01, 1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 50, 32, 2'b00, 2'b00, 1));
        tbl.push_back(mk(1, 1, 0, 100, 0, 1, 64, 32, 2'b00, 2'b01, 1));
        tbl.push_back(mk(1, 1, 0, 0,   0, 0, 0,  32, 2'b00, 2'b01, 1));
        tbl.push_back(mk(1, 1, 1, 32,  1, 0, 0,  32, 2'b00, 2'b10, 1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0,  32, 2'b00, 2'b00, 1));
        tbl.push_back(mk(1, 1, 1, 35,  1, 0, 0,  32, 2'b10, 2'b00, 1));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].ch, tbl[i].code, tbl[i].rp, tbl[i].h);
            check($sformatf("vec%0d", i), tbl[i].c0, tbl[i].c1, tbl[i].b, tbl[i].d, tbl[i].rdy);
        end

        // ch1 ramp 32->35, accepted on the last table edge
        for (int k = 1; k <= 13; k++) begin
            apply(1, 0, 0, 0, 0, 0);
            check($sformatf("ramp k%0d", k), 0, 32 + k / 4,
                  {1'(k < 12), 1'b0}, {1'(k == 12), 1'b0}, 1);
        end

        // redirect mid-ramp with hold
        apply(1, 1, 0, 32, 0, 0);
        check("redir imm32", 32, 35, 2'b00, 2'b01, 1);
        apply(1, 1, 0, 40, 1, 0);
        check("redir go40", 32, 35, 2'b01, 2'b00, 1);
        for (int k = 1; k <= 8; k++) begin
            apply(1, 0, 0, 0, 0, 0);
            check($sformatf("up k%0d", k), 32 + k / 4, 35, 2'b01, 2'b00, 1);
        end
        apply(1, 1, 0, 30, 1, 0);
        check("redir go30", 34, 35, 2'b01, 2'b00, 1);
        for (int n = 1; n <= 21; n++) begin
            int e;
            e = 34 - int'(n >= 9) - int'(n >= 13) - int'(n >= 17) - int'(n >= 21);
            apply(1, 0, 0, 0, 0, 1'(n <= 5));
            check($sformatf("down n%0d", n), e, 35, {1'b0, 1'(n < 21)},
                  {1'b0, 1'(n == 21)}, 1);
        end

        // reset while ramping abandons the ramp without done
        apply(1, 1, 0, 60, 1, 0);
        check("rst go60", 30, 35, 2'b01, 2'b00, 1);
        for (int k = 1; k <= 28; k++) apply(1, 0, 0, 0, 0, 0);
        check("rst pre", 37, 35, 2'b01, 2'b00, 1);
        apply(0, 0, 0, 0, 0, 0);
        check("rst mid", 32, 32, 2'b00, 2'b00, 0);
        apply(1, 0, 0, 0, 0, 0);
        check("rst rel", 32, 32, 2'b00, 2'b00, 1);
        apply(1, 1, 1, 10, 0, 1);
        check("hold imm", 32, 10, 2'b00, 2'b10, 1);
        apply(1, 0, 0, 0, 0, 0);
        check("hold idle", 32, 10, 2'b00, 2'b00, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
